// File: rtl/sched_pkg.sv
// Shared types and helpers for the preemptive round-robin process scheduler.
package sched_pkg;

    typedef enum logic [1:0] {
        FREE,
        READY,
        RUNNING,
        BLOCKED
    } slot_state_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SAVE,
        SELECT,
        DISPATCH
    } fsm_state_t;

    // Slot index width; at least one bit so a two-slot system still has a pid.
    function automatic int pid_width(input int nproc);
        return (nproc <= 2) ? 1 : $clog2(nproc);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating priority encoder: first set bit of req at or after start, wrapping
// modulo NPROC (also correct for non-power-of-two NPROC).
module rr_arbiter #(
    parameter int NPROC = 8,
    parameter int PID_W = 3
) (
    input  logic [NPROC-1:0] req,
    input  logic [PID_W-1:0] start,
    output logic [PID_W-1:0] grant,
    output logic             any_grant
);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        any_grant = 1'b0;
        for (int i = 0; i < NPROC; i++) begin
            idx = (int'(start) + i) % NPROC;
            if (!any_grant && req[idx]) begin
                any_grant = 1'b1;
                grant     = PID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/quantum_scheduler.sv
// Preemptive round-robin scheduler: per-slot state and saved PC, quantum
// counting on retired instructions, and a valid/ack context-switch handshake.
module quantum_scheduler
    import sched_pkg::*;
#(
    parameter int NPROC           = 8,
    parameter int PC_W            = 32,
    parameter int QUANTUM_W       = 8,
    parameter int DEFAULT_QUANTUM = 16,
    localparam int PID_W          = pid_width(NPROC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 instr_retire,
    input  logic [PC_W-1:0]      pc,
    input  logic                 io_req,
    input  logic                 proc_exit,
    input  logic                 io_done,
    input  logic [PID_W-1:0]     io_done_pid,
    input  logic                 create_valid,
    input  logic [PID_W-1:0]     create_pid,
    input  logic [PC_W-1:0]      create_pc,
    input  logic                 quantum_load,
    input  logic [QUANTUM_W-1:0] quantum_value,
    output logic                 switch_valid,
    output logic [PC_W-1:0]      switch_pc,
    input  logic                 switch_ack,
    output logic [PID_W-1:0]     current_pid,
    output logic                 running,
    output logic                 idle,
    output logic                 create_err,
    output logic [NPROC-1:0]     ready_mask,
    output fsm_state_t           fsm_state
);

    // Handshake: switch_valid rises with switch_pc/current_pid already stable
    // and holds them until the cycle switch_ack is sampled high; that cycle the
    // slot becomes RUNNING and switch_valid drops on the following edge.

    localparam logic [PID_W:0] NPROC_L = (PID_W + 1)'(NPROC);

    fsm_state_t           state_q, state_d;
    slot_state_t          slot_q [NPROC];
    slot_state_t          slot_d [NPROC];
    logic [PC_W-1:0]      spc_q [NPROC];
    logic [PC_W-1:0]      spc_d [NPROC];
    logic [PID_W-1:0]     cur_q, cur_d;
    logic [QUANTUM_W-1:0] count_q, count_d;
    logic [QUANTUM_W-1:0] quantum_q, quantum_d;
    logic [QUANTUM_W-1:0] pend_q, pend_d;
    slot_state_t          save_state_q, save_state_d;
    logic [PC_W-1:0]      save_pc_q, save_pc_d;
    logic [PC_W-1:0]      switch_pc_q, switch_pc_d;
    logic                 create_err_q, create_err_d;

    logic [PID_W-1:0]     start_idx;
    logic [PID_W-1:0]     grant;
    logic                 any_grant;
    logic                 io_ok, create_ok;

    always_comb begin
        ready_mask = '0;
        for (int i = 0; i < NPROC; i++) begin
            ready_mask[i] = (slot_q[i] == READY);
        end
    end

    // The running slot is searched last: the scan begins just past it.
    assign start_idx = (cur_q == PID_W'(NPROC - 1)) ? '0 : cur_q + PID_W'(1);
    assign io_ok     = {1'b0, io_done_pid} < NPROC_L;
    assign create_ok = {1'b0, create_pid} < NPROC_L;

    rr_arbiter #(
        .NPROC(NPROC),
        .PID_W(PID_W)
    ) u_arb (
        .req      (ready_mask),
        .start    (start_idx),
        .grant    (grant),
        .any_grant(any_grant)
    );

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        spc_d        = spc_q;
        cur_d        = cur_q;
        count_d      = count_q;
        quantum_d    = quantum_q;
        pend_d       = pend_q;
        save_state_d = save_state_q;
        save_pc_d    = save_pc_q;
        switch_pc_d  = switch_pc_q;
        create_err_d = 1'b0;

        if (io_done && io_ok && slot_q[io_done_pid] == BLOCKED) begin
            slot_d[io_done_pid] = READY;
        end
        // Judged on the pre-cycle state, so a same-cycle wake still rejects it.
        if (create_valid) begin
            if (create_ok && slot_q[create_pid] == FREE) begin
                slot_d[create_pid] = READY;
                spc_d[create_pid]  = create_pc;
            end else begin
                create_err_d = 1'b1;
            end
        end
        if (quantum_load) begin
            pend_d = (quantum_value == '0) ? QUANTUM_W'(1) : quantum_value;
        end

        case (state_q)
            IDLE: begin
                if (|ready_mask) state_d = SELECT;
            end
            RUN: begin
                if (!stall && instr_retire) begin
                    if (proc_exit) begin
                        save_state_d = FREE;
                        count_d      = '0;
                        state_d      = SAVE;
                    end else if (io_req) begin
                        save_state_d = BLOCKED;
                        save_pc_d    = pc + PC_W'(1);
                        count_d      = '0;
                        state_d      = SAVE;
                    end else if (count_q == quantum_q - QUANTUM_W'(1)) begin
                        save_state_d = READY;
                        save_pc_d    = pc + PC_W'(1);
                        count_d      = '0;
                        state_d      = SAVE;
                    end else begin
                        count_d = count_q + QUANTUM_W'(1);
                    end
                end
            end
            SAVE: begin
                slot_d[cur_q] = save_state_q;
                if (save_state_q != FREE) spc_d[cur_q] = save_pc_q;
                state_d = SELECT;
            end
            SELECT: begin
                if (any_grant) begin
                    cur_d       = grant;
                    switch_pc_d = spc_q[grant];
                    state_d     = DISPATCH;
                end else begin
                    state_d = IDLE;
                end
            end
            DISPATCH: begin
                if (switch_ack) begin
                    slot_d[cur_q] = RUNNING;
                    count_d       = '0;
                    quantum_d     = pend_q;
                    state_d       = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            for (int i = 0; i < NPROC; i++) begin
                slot_q[i] <= FREE;
                spc_q[i]  <= '0;
            end
            cur_q        <= '0;
            count_q      <= '0;
            quantum_q    <= QUANTUM_W'(DEFAULT_QUANTUM);
            pend_q       <= QUANTUM_W'(DEFAULT_QUANTUM);
            save_state_q <= FREE;
            save_pc_q    <= '0;
            switch_pc_q  <= '0;
            create_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            spc_q        <= spc_d;
            cur_q        <= cur_d;
            count_q      <= count_d;
            quantum_q    <= quantum_d;
            pend_q       <= pend_d;
            save_state_q <= save_state_d;
            save_pc_q    <= save_pc_d;
            switch_pc_q  <= switch_pc_d;
            create_err_q <= create_err_d;
        end
    end

    assign switch_valid = (state_q == DISPATCH);
    assign switch_pc    = switch_pc_q;
    assign current_pid  = cur_q;
    assign running      = (state_q == RUN);
    assign idle         = (state_q == IDLE);
    assign create_err   = create_err_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed bench for quantum_scheduler: dispatch order, quanta, IO block/wake,
// create errors, stall freeze and asynchronous reset during a pending switch.
module tb_quantum_scheduler;
    import sched_pkg::*;

    localparam int NPROC     = 8;
    localparam int PC_W      = 32;
    localparam int QUANTUM_W = 8;
    localparam int PID_W     = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 stall;
    logic                 instr_retire;
    logic [PC_W-1:0]      pc;
    logic                 io_req;
    logic                 proc_exit;
    logic                 io_done;
    logic [PID_W-1:0]     io_done_pid;
    logic                 create_valid;
    logic [PID_W-1:0]     create_pid;
    logic [PC_W-1:0]      create_pc;
    logic                 quantum_load;
    logic [QUANTUM_W-1:0] quantum_value;
    logic                 switch_valid;
    logic [PC_W-1:0]      switch_pc;
    logic                 switch_ack;
    logic [PID_W-1:0]     current_pid;
    logic                 running;
    logic                 idle;
    logic                 create_err;
    logic [NPROC-1:0]     ready_mask;
    fsm_state_t           fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [PID_W+PC_W-1:0] exp_q[$];

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    quantum_scheduler #(
        .NPROC(NPROC),
        .PC_W(PC_W),
        .QUANTUM_W(QUANTUM_W),
        .DEFAULT_QUANTUM(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .instr_retire (instr_retire),
        .pc           (pc),
        .io_req       (io_req),
        .proc_exit    (proc_exit),
        .io_done      (io_done),
        .io_done_pid  (io_done_pid),
        .create_valid (create_valid),
        .create_pid   (create_pid),
        .create_pc    (create_pc),
        .quantum_load (quantum_load),
        .quantum_value(quantum_value),
        .switch_valid (switch_valid),
        .switch_pc    (switch_pc),
        .switch_ack   (switch_ack),
        .current_pid  (current_pid),
        .running      (running),
        .idle         (idle),
        .create_err   (create_err),
        .ready_mask   (ready_mask),
        .fsm_state    (fsm_state)
    );

    // Scoreboard comparison
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [PC_W-1:0] p, input logic io, input logic ex,
                          input logic exp_run);
        instr_retire = 1'b1;
        pc           = p;
        io_req       = io;
        proc_exit    = ex;
        step();
        instr_retire = 1'b0;
        io_req       = 1'b0;
        proc_exit    = 1'b0;
        check("running_after_retire", running, exp_run);
    endtask

    task automatic run_slice(input logic [PC_W-1:0] base, input int n);
        for (int i = 0; i < n - 1; i++) retire(base + PC_W'(i), 1'b0, 1'b0, 1'b1);
        retire(base + PC_W'(n - 1), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_create(input logic [PID_W-1:0] pid, input logic [PC_W-1:0] p);
        create_valid = 1'b1;
        create_pid   = pid;
        create_pc    = p;
        step();
        create_valid = 1'b0;
    endtask

    task automatic load_quantum(input logic [QUANTUM_W-1:0] q);
        quantum_load  = 1'b1;
        quantum_value = q;
        step();
        quantum_load  = 1'b0;
    endtask

    task automatic expect_dispatch(input logic [PID_W-1:0] pid, input logic [PC_W-1:0] p);
        exp_q.push_back({pid, p});
    endtask

    task automatic wait_dispatch();
        int n;
        logic [PID_W+PC_W-1:0] e;
        n = 0;
        while (!switch_valid && n < 20) begin
            step();
            n++;
        end
        check("dispatch_latency", n, 2);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("switch_valid", switch_valid, 1);
        check("switch_pc", switch_pc, e[PC_W-1:0]);
        check("current_pid", current_pid, e[PC_W+:PID_W]);
        step();
        check("switch_valid_hold", switch_valid, 1);
        check("switch_pc_hold", switch_pc, e[PC_W-1:0]);
    endtask

    task automatic ack();
        switch_ack = 1'b1;
        step();
        switch_ack = 1'b0;
        check("running_after_ack", running, 1);
        check("switch_valid_after_ack", switch_valid, 0);
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        instr_retire  = 1'b0;
        pc            = '0;
        io_req        = 1'b0;
        proc_exit     = 1'b0;
        io_done       = 1'b0;
        io_done_pid   = '0;
        create_valid  = 1'b0;
        create_pid    = '0;
        create_pc     = '0;
        quantum_load  = 1'b0;
        quantum_value = '0;
        switch_ack    = 1'b0;
        step();
        step();
        check("rst_switch_valid", switch_valid, 0);
        check("rst_switch_pc", switch_pc, 0);
        check("rst_current_pid", current_pid, 0);
        check("rst_running", running, 0);
        check("rst_idle", idle, 1);
        check("rst_create_err", create_err, 0);
        check("rst_ready_mask", ready_mask, 0);
        reset = 1'b0;
        step();

        // Single process, quantum 4: re-dispatched after 4 retires
        load_quantum(8'd4);
        do_create(3'd0, 32'h10);
        check("create0_err", create_err, 0);
        check("create0_mask", ready_mask, 8'h01);
        expect_dispatch(3'd0, 32'h10);
        wait_dispatch();
        ack();
        run_slice(32'h10, 4);
        expect_dispatch(3'd0, 32'h14);
        wait_dispatch();
        ack();

        // Load 0 mid-slice and stall: slice still 4, count frozen, next slice 1
        retire(32'h14, 1'b0, 1'b0, 1'b1);
        retire(32'h15, 1'b0, 1'b0, 1'b1);
        load_quantum(8'd0);
        stall        = 1'b1;
        instr_retire = 1'b1;
        pc           = 32'hdead;
        repeat (10) step();
        check("running_during_stall", running, 1);
        stall        = 1'b0;
        instr_retire = 1'b0;
        retire(32'h16, 1'b0, 1'b0, 1'b1);
        retire(32'h17, 1'b0, 1'b0, 1'b0);
        expect_dispatch(3'd0, 32'h18);
        wait_dispatch();
        ack();
        retire(32'h18, 1'b0, 1'b0, 1'b0);
        expect_dispatch(3'd0, 32'h19);
        wait_dispatch();
        load_quantum(8'd4);
        ack();

        // Exit plus io_req: slot must end FREE, so io_done cannot wake it
        do_create(3'd5, 32'h500);
        check("create5_mask", ready_mask, 8'h20);
        retire(32'h19, 1'b1, 1'b1, 1'b0);
        expect_dispatch(3'd5, 32'h500);
        wait_dispatch();
        ack();
        io_done     = 1'b1;
        io_done_pid = 3'd0;
        step();
        io_done     = 1'b0;
        check("exit_not_blocked_mask", ready_mask, 8'h00);

        // Create on a RUNNING slot
        do_create(3'd5, 32'h555);
        check("create_running_err", create_err, 1);
        check("create_running_mask", ready_mask, 8'h00);
        check("create_running_still_run", running, 1);
        step();
        check("create_err_pulse", create_err, 0);

        // Round robin 5 -> 7 -> 2 -> 5
        do_create(3'd2, 32'h200);
        do_create(3'd7, 32'h700);
        check("rr_mask", ready_mask, 8'h84);
        run_slice(32'h500, 4);
        expect_dispatch(3'd7, 32'h700);
        wait_dispatch();
        ack();
        run_slice(32'h700, 4);
        expect_dispatch(3'd2, 32'h200);
        wait_dispatch();
        ack();
        run_slice(32'h200, 4);
        expect_dispatch(3'd5, 32'h504);
        wait_dispatch();
        ack();

        // Drain everything, then IO block/wake on pid1
        retire(32'h504, 1'b0, 1'b1, 1'b0);
        expect_dispatch(3'd7, 32'h704);
        wait_dispatch();
        ack();
        retire(32'h704, 1'b0, 1'b1, 1'b0);
        expect_dispatch(3'd2, 32'h204);
        wait_dispatch();
        ack();
        retire(32'h204, 1'b0, 1'b1, 1'b0);
        step();
        step();
        check("drained_idle", idle, 1);
        check("drained_mask", ready_mask, 8'h00);
        do_create(3'd1, 32'h40);
        expect_dispatch(3'd1, 32'h40);
        wait_dispatch();
        ack();
        retire(32'h40, 1'b1, 1'b0, 1'b0);
        step();
        step();
        check("blocked_idle", idle, 1);
        check("blocked_mask", ready_mask, 8'h00);
        check("blocked_switch_valid", switch_valid, 0);
        io_done      = 1'b1;
        io_done_pid  = 3'd1;
        create_valid = 1'b1;
        create_pid   = 3'd1;
        create_pc    = 32'h999;
        step();
        io_done      = 1'b0;
        create_valid = 1'b0;
        check("wake_create_err", create_err, 1);
        check("wake_mask", ready_mask, 8'h02);
        expect_dispatch(3'd1, 32'h41);
        wait_dispatch();

        // Asynchronous reset while a switch is pending
        #3;
        reset = 1'b1;
        #1;
        check("arst_switch_valid", switch_valid, 0);
        check("arst_idle", idle, 1);
        check("arst_mask", ready_mask, 8'h00);
        check("arst_running", running, 0);
        check("arst_current_pid", current_pid, 0);
        check("arst_switch_pc", switch_pc, 0);
        #2;
        reset = 1'b0;
        step();
        check("post_rst_idle", idle, 1);
        check("post_rst_mask", ready_mask, 8'h00);

        // Quantum back to DEFAULT_QUANTUM after reset
        do_create(3'd3, 32'h300);
        expect_dispatch(3'd3, 32'h300);
        wait_dispatch();
        ack();
        run_slice(32'h300, 16);
        expect_dispatch(3'd3, 32'h310);
        wait_dispatch();
        ack();

        // Final report
        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
